// File: rtl/vga_regport.sv
// Host register port for the text-mode VGA controller: decodes byte-wide register
// accesses, writes characters/attributes to VRAM/CRAM, owns the cursor and a screen fill.
module vga_regport #(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_l,
  input  logic              i_cs_h,
  input  logic              i_rl_wh,
  input  logic [2:0]        i_reg,
  input  logic [7:0]        i_port,
  output logic [7:0]        o_port,
  output logic              o_ready_h,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [7:0]        o_vram_data,
  output logic              o_vram_we_h,
  output logic [ADDR_W-1:0] o_cram_addr,
  output logic [7:0]        o_cram_data,
  output logic              o_cram_we_h,
  output logic [ADDR_W-1:0] o_cursor_addr,
  output logic              o_cursor_enable_h
);

  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W:0]   CELLS_C   = (ADDR_W + 1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_FILL,
    ST_RELEASE
  } state_t;

  state_t            state_reg;
  logic [2:0]        reg_sel_reg;
  logic              rw_reg;
  logic [7:0]        data_reg;
  logic [7:0]        control_reg;
  logic [7:0]        color_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] cursor_reg;
  logic [ADDR_W-1:0] fill_cnt_reg;

  logic [7:0]        rd_val;
  logic [ADDR_W-1:0] cur_next;
  logic              cur_oob;

  always_comb begin
    rd_val = 8'hFF;
    case (reg_sel_reg)
      3'd0:    rd_val = {3'b101, 2'b00, err_reg, 1'b0, 1'b1};
      3'd2:    rd_val = cursor_reg[7:0];
      3'd3:    rd_val = 8'(cursor_reg[ADDR_W-1:8]);
      3'd4:    rd_val = control_reg;
      3'd5:    rd_val = color_reg;
      3'd7:    rd_val = 8'hEE;
      default: rd_val = 8'hFF;
    endcase
  end

  // A cursor write replaces one byte half; the other half keeps its current value.
  always_comb begin
    cur_next = cursor_reg;
    if (reg_sel_reg == 3'd2)
      cur_next = {cursor_reg[ADDR_W-1:8], data_reg};
    else
      cur_next = {data_reg[ADDR_W-9:0], cursor_reg[7:0]};
    cur_oob = ({1'b0, cur_next} >= CELLS_C);
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state_reg    <= ST_IDLE;
      reg_sel_reg  <= 3'd0;
      rw_reg       <= 1'b0;
      data_reg     <= 8'h00;
      control_reg  <= 8'h03;
      color_reg    <= 8'h07;
      err_reg      <= 1'b0;
      cursor_reg   <= '0;
      fill_cnt_reg <= '0;
      o_port       <= 8'h00;
      o_ready_h    <= 1'b1;
      o_vram_addr  <= '0;
      o_vram_data  <= 8'h00;
      o_vram_we_h  <= 1'b0;
      o_cram_addr  <= '0;
      o_cram_data  <= 8'h00;
      o_cram_we_h  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_cs_h && o_ready_h) begin
            reg_sel_reg <= i_reg;
            rw_reg      <= i_rl_wh;
            data_reg    <= i_port;
            o_ready_h   <= 1'b0;
            state_reg   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!rw_reg) begin
            o_port <= rd_val;
            if (reg_sel_reg == 3'd0)
              err_reg <= 1'b0;
            state_reg <= ST_RELEASE;
          end else begin
            state_reg <= ST_RELEASE;
            case (reg_sel_reg)
              3'd1: begin
                o_vram_addr <= cursor_reg;
                o_cram_addr <= cursor_reg;
                o_vram_data <= data_reg;
                o_cram_data <= color_reg;
                o_vram_we_h <= 1'b1;
                o_cram_we_h <= 1'b1;
                state_reg   <= ST_WRITE;
              end
              3'd2, 3'd3: begin
                cursor_reg <= cur_oob ? '0 : cur_next;
                if (cur_oob)
                  err_reg <= 1'b1;
              end
              3'd4: control_reg <= data_reg;
              3'd5: color_reg   <= data_reg;
              3'd6: begin
                // Cell 0 is presented here so the fill is CELLS back-to-back strobes.
                fill_cnt_reg <= '0;
                o_vram_addr  <= '0;
                o_cram_addr  <= '0;
                o_vram_data  <= data_reg;
                o_cram_data  <= color_reg;
                o_vram_we_h  <= 1'b1;
                o_cram_we_h  <= 1'b1;
                state_reg    <= ST_FILL;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          o_vram_we_h <= 1'b0;
          o_cram_we_h <= 1'b0;
          if (control_reg[1])
            cursor_reg <= (cursor_reg == LAST_CELL) ? '0 : cursor_reg + 1'b1;
          state_reg <= ST_RELEASE;
        end
        ST_FILL: begin
          if (fill_cnt_reg == LAST_CELL) begin
            o_vram_we_h <= 1'b0;
            o_cram_we_h <= 1'b0;
            cursor_reg  <= '0;
            state_reg   <= ST_RELEASE;
          end else begin
            fill_cnt_reg <= fill_cnt_reg + 1'b1;
            o_vram_addr  <= fill_cnt_reg + 1'b1;
            o_cram_addr  <= fill_cnt_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!i_cs_h) begin
            o_ready_h <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_cursor_addr     = cursor_reg;
  assign o_cursor_enable_h = control_reg[0];

endmodule

// File: tb/tb_vga_regport.sv
// Bench for vga_regport: an 80x25 instance driven by directed and random host traffic
// against a register-level model, plus a 64x30 instance for the alternate geometry.
module tb_vga_regport;

  localparam int AW      = 11;
  localparam int CELLS_A = 2000;

  typedef struct {
    int addr;
    int vd;
    int cd;
    int edge_no;
    bit ok;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0, rl_wh = 1'b0, sel = 1'b0;
  logic [2:0] reg_sel = 3'd0;
  logic [7:0] port_in = 8'h00;

  logic [7:0] port_a, vdata_a, cdata_a, port_b, vdata_b, cdata_b;
  logic [AW-1:0] vaddr_a, caddr_a, cur_a, vaddr_b, caddr_b, cur_b;
  logic rdy_a, vwe_a, cwe_a, en_a, rdy_b, vwe_b, cwe_b, en_b;
  logic cs_a, cs_b, rdy;
  logic [7:0] port_rd;

  assign cs_a    = cs & ~sel;
  assign cs_b    = cs & sel;
  assign rdy     = sel ? rdy_b : rdy_a;
  assign port_rd = sel ? port_b : port_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_during_we = 0;
  wr_t obs_a[$];
  wr_t obs_b[$];
  wr_t mon_a, mon_b;

  int m_cur, m_ctrl, m_color;
  bit m_err;

  vga_regport #(.COLS(80), .ROWS(25), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_l(rst_n), .i_cs_h(cs_a), .i_rl_wh(rl_wh), .i_reg(reg_sel),
    .i_port(port_in), .o_port(port_a), .o_ready_h(rdy_a),
    .o_vram_addr(vaddr_a), .o_vram_data(vdata_a), .o_vram_we_h(vwe_a),
    .o_cram_addr(caddr_a), .o_cram_data(cdata_a), .o_cram_we_h(cwe_a),
    .o_cursor_addr(cur_a), .o_cursor_enable_h(en_a));

  vga_regport #(.COLS(64), .ROWS(30), .ADDR_W(AW)) dut_small (
    .i_clk(clk), .i_rst_l(rst_n), .i_cs_h(cs_b), .i_rl_wh(rl_wh), .i_reg(reg_sel),
    .i_port(port_in), .o_port(port_b), .o_ready_h(rdy_b),
    .o_vram_addr(vaddr_b), .o_vram_data(vdata_b), .o_vram_we_h(vwe_b),
    .o_cram_addr(caddr_b), .o_cram_data(cdata_b), .o_cram_we_h(cwe_b),
    .o_cursor_addr(cur_b), .o_cursor_enable_h(en_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors: edge_no is the clock edge on which the RAM captures the strobe.
  always @(negedge clk) begin
    if (vwe_a || cwe_a) begin
      mon_a.addr = int'(vaddr_a); mon_a.vd = int'(vdata_a); mon_a.cd = int'(cdata_a);
      mon_a.edge_no = cyc + 1; mon_a.ok = (vaddr_a == caddr_a) && vwe_a && cwe_a;
      obs_a.push_back(mon_a);
      if (rdy_a) ready_during_we <= ready_during_we + 1;
    end
    if (vwe_b || cwe_b) begin
      mon_b.addr = int'(vaddr_b); mon_b.vd = int'(vdata_b); mon_b.cd = int'(cdata_b);
      mon_b.edge_no = cyc + 1; mon_b.ok = (vaddr_b == caddr_b) && vwe_b && cwe_b;
      obs_b.push_back(mon_b);
    end
  end

  // Register-level model of the 80x25 instance.
  function automatic void m_reset();
    m_cur = 0; m_ctrl = 3; m_color = 7; m_err = 0;
  endfunction

  function automatic void m_set_cursor(input int nv);
    if (nv >= CELLS_A) begin m_cur = 0; m_err = 1; end
    else m_cur = nv;
  endfunction

  function automatic int m_write(input int r, input int d);
    int n = 0;
    case (r)
      1: begin
        n = 1;
        if ((m_ctrl & 2) != 0) m_cur = (m_cur + 1) % CELLS_A;
      end
      2: m_set_cursor((m_cur / 256) * 256 + d);
      3: m_set_cursor((d % (1 << (AW - 8))) * 256 + (m_cur % 256));
      4: m_ctrl = d;
      5: m_color = d;
      default: ;
    endcase
    return n;
  endfunction

  function automatic int m_read(input int r);
    int v;
    case (r)
      0: begin v = 8'hA1 + (m_err ? 4 : 0); m_err = 0; end
      2: v = m_cur % 256;
      3: v = m_cur / 256;
      4: v = m_ctrl;
      5: v = m_color;
      7: v = 8'hEE;
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  task automatic host_start(input logic rw, input logic [2:0] r, input logic [7:0] d,
                            output int acc);
    bit got = 0;
    @(negedge clk);
    cs = 1'b1; rl_wh = rw; reg_sel = r; port_in = d;
    acc = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (!rdy) begin got = 1; acc = cyc; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout reg %0d ready=%b, required 0 after request", r, rdy);
    end
  endtask

  task automatic host_finish(input int bound);
    bit got = 0;
    cs = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (rdy) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout ready=%b, required 1 within %0d cycles", rdy, bound);
    end
  endtask

  task automatic host_write(input logic [2:0] r, input logic [7:0] d, output int acc);
    host_start(1'b1, r, d, acc);
    host_finish(3000);
  endtask

  task automatic host_read(input logic [2:0] r, output logic [7:0] v);
    int acc;
    host_start(1'b0, r, 8'h00, acc);
    @(negedge clk);
    @(negedge clk);
    v = port_rd;
    host_finish(50);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0; cs = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({port_a, vaddr_a, vdata_a, vwe_a, caddr_a, cdata_a, cwe_a, cur_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs port=%h va=%h vd=%h vwe=%b ca=%h cd=%h cwe=%b cur=%h, required all 0",
               port_a, vaddr_a, vdata_a, vwe_a, caddr_a, cdata_a, cwe_a, cur_a);
    end
    checks++;
    if (rdy_a !== 1'b1 || en_a !== 1'b1) begin
      errors++; $display("FAIL reset_ready_en ready=%b en=%b, required 1 1", rdy_a, en_a);
    end
    rst_n = 1'b1; m_reset(); obs_a.delete(); obs_b.delete();
    @(negedge clk);
    host_read(3'd0, v);
    checks++; if (v !== 8'hA1) begin errors++; $display("FAIL reset_status got %h, required a1", v); end
    host_read(3'd4, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL reset_control got %h, required 03", v); end
    host_read(3'd5, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL reset_color got %h, required 07", v); end
    host_read(3'd7, v);
    checks++; if (v !== 8'hEE) begin errors++; $display("FAIL read_unmapped got %h, required ee", v); end
    host_read(3'd1, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL read_data got %h, required ff", v); end
    host_read(3'd6, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL read_fill got %h, required ff", v); end
  endtask

  task automatic test_defaults();
    int acc;
    host_write(3'd5, 8'h1E, acc); void'(m_write(5, 'h1E));
    host_write(3'd2, 8'hCF, acc); void'(m_write(2, 'hCF));
    host_write(3'd3, 8'h07, acc); void'(m_write(3, 'h07));
    obs_a.delete();
    host_write(3'd1, 8'h41, acc); void'(m_write(1, 'h41));
    checks++;
    if (obs_a.size() != 1) begin
      errors++; $display("FAIL char_write_count got %0d, required 1", obs_a.size());
    end else begin
      checks++;
      if (obs_a[0].addr != 'h7CF || obs_a[0].vd != 'h41 || obs_a[0].cd != 'h1E || !obs_a[0].ok) begin
        errors++;
        $display("FAIL char_write addr=%h vd=%h cd=%h ok=%0d, required 7cf 41 1e 1",
                 obs_a[0].addr, obs_a[0].vd, obs_a[0].cd, obs_a[0].ok);
      end
      checks++;
      if (obs_a[0].edge_no != acc + 2) begin
        errors++; $display("FAIL char_latency strobe edge %0d, required %0d", obs_a[0].edge_no, acc + 2);
      end
    end
    checks++;
    if (cur_a !== 11'h000) begin errors++; $display("FAIL cursor_wrap got %h, required 000", cur_a); end
  endtask

  task automatic test_no_autoinc();
    int acc;
    host_write(3'd4, 8'h01, acc); void'(m_write(4, 'h01));
    host_write(3'd2, 8'h05, acc); void'(m_write(2, 'h05));
    host_write(3'd3, 8'h00, acc); void'(m_write(3, 'h00));
    obs_a.delete();
    host_write(3'd1, 8'h42, acc); void'(m_write(1, 'h42));
    host_write(3'd1, 8'h42, acc); void'(m_write(1, 'h42));
    checks++;
    if (obs_a.size() != 2) begin
      errors++; $display("FAIL noinc_count got %0d, required 2", obs_a.size());
    end else begin
      checks++;
      if (obs_a[0].addr != 5 || obs_a[1].addr != 5 || obs_a[1].vd != 'h42 || obs_a[1].cd != 'h1E) begin
        errors++;
        $display("FAIL noinc_addr got %h/%h vd=%h cd=%h, required 005/005 42 1e",
                 obs_a[0].addr, obs_a[1].addr, obs_a[1].vd, obs_a[1].cd);
      end
    end
    checks++;
    if (cur_a !== 11'd5 || en_a !== 1'b1) begin
      errors++; $display("FAIL noinc_cursor cur=%h en=%b, required 005 1", cur_a, en_a);
    end
    host_write(3'd4, 8'h03, acc); void'(m_write(4, 'h03));
  endtask

  task automatic test_range_err();
    int acc;
    logic [7:0] v;
    host_write(3'd2, 8'hD0, acc); void'(m_write(2, 'hD0));
    host_write(3'd3, 8'h07, acc); void'(m_write(3, 'h07));
    checks++;
    if (cur_a !== 11'd0) begin errors++; $display("FAIL oob_cursor got %h, required 000", cur_a); end
    host_read(3'd0, v); void'(m_read(0));
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL err_status got %h, required a5", v); end
    host_read(3'd0, v); void'(m_read(0));
    checks++; if (v !== 8'hA1) begin errors++; $display("FAIL err_cleared got %h, required a1", v); end
  endtask

  task automatic test_fill();
    int acc, bad, first_bad;
    host_write(3'd5, 8'h07, acc); void'(m_write(5, 'h07));
    host_write(3'd2, 8'h23, acc); void'(m_write(2, 'h23));
    host_write(3'd3, 8'h01, acc); void'(m_write(3, 'h01));
    obs_a.delete(); ready_during_we = 0;
    host_write(3'd6, 8'h20, acc); m_cur = 0;
    checks++;
    if (obs_a.size() != CELLS_A) begin
      errors++; $display("FAIL fill_count got %0d, required %0d", obs_a.size(), CELLS_A);
    end else begin
      bad = 0; first_bad = -1;
      for (int i = 0; i < CELLS_A; i++) begin
        if (obs_a[i].addr != i || obs_a[i].vd != 'h20 || obs_a[i].cd != 'h07 || !obs_a[i].ok ||
            obs_a[i].edge_no != obs_a[0].edge_no + i) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL fill_cells %0d bad, first at %0d: addr=%h vd=%h cd=%h edge=%0d, required %h 20 07 %0d",
                 bad, first_bad, obs_a[first_bad].addr, obs_a[first_bad].vd, obs_a[first_bad].cd,
                 obs_a[first_bad].edge_no, first_bad, obs_a[0].edge_no + first_bad);
      end
    end
    checks++;
    if (ready_during_we != 0) begin
      errors++; $display("FAIL fill_ready ready high on %0d write cycles, required 0", ready_during_we);
    end
    checks++;
    if (cur_a !== 11'd0) begin errors++; $display("FAIL fill_cursor got %h, required 000", cur_a); end
  endtask

  task automatic test_reset_mid_fill();
    int acc, n_before;
    bit hit = 0;
    logic [7:0] v;
    host_write(3'd5, 8'h4C, acc);
    host_write(3'd4, 8'h02, acc);
    host_write(3'd2, 8'h10, acc);
    checks++;
    if (en_a !== 1'b0) begin errors++; $display("FAIL ctrl_enable_off got %b, required 0", en_a); end
    host_start(1'b1, 3'd6, 8'h20, acc);
    cs = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (vwe_a && vaddr_a == 11'd100) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL fill_cell100 never reached, vaddr=%h", vaddr_a); end
    #1 rst_n = 1'b0;
    #1;
    n_before = obs_a.size();
    checks++;
    if (vwe_a !== 1'b0 || cwe_a !== 1'b0) begin
      errors++; $display("FAIL reset_we vwe=%b cwe=%b, required 0 0", vwe_a, cwe_a);
    end
    checks++;
    if ({port_a, vaddr_a, vdata_a, caddr_a, cdata_a, cur_a} !== '0 || rdy_a !== 1'b1 || en_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fill va=%h vd=%h ca=%h cd=%h cur=%h rdy=%b en=%b, required 0s rdy 1 en 1",
               vaddr_a, vdata_a, caddr_a, cdata_a, cur_a, rdy_a, en_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1; m_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a.size() != n_before) begin
      errors++; $display("FAIL writes_after_reset got %0d extra, required 0", obs_a.size() - n_before);
    end
    host_read(3'd5, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL color_after_reset got %h, required 07", v); end
    host_read(3'd4, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL ctrl_after_reset got %h, required 03", v); end
  endtask

  task automatic test_hold_cs();
    int acc, early = 0, exp_addr;
    exp_addr = m_cur;
    obs_a.delete();
    host_start(1'b1, 3'd1, 8'h33, acc); void'(m_write(1, 'h33));
    while (cyc < acc + 12) begin
      @(negedge clk);
      if (rdy_a) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL hold_ready rose %0d times with cs held, required 0", early); end
    cs = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1) begin errors++; $display("FAIL hold_release ready=%b one edge after cs fell, required 1", rdy_a); end
    checks++;
    if (obs_a.size() != 1 || obs_a[0].addr != exp_addr || obs_a[0].vd != 'h33) begin
      errors++; $display("FAIL hold_single_write got %0d writes, required 1 at %h", obs_a.size(), exp_addr);
    end
  endtask

  task automatic test_random();
    int acc, r, d, nexp, expv;
    logic rw;
    logic [7:0] v;
    int cur_before, color_before;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 7); d = $urandom_range(0, 255); rw = 1'($urandom_range(0, 1));
      if (rw && r == 6) r = 1;
      if (rw) begin
        obs_a.delete();
        cur_before = m_cur; color_before = m_color;
        host_write(3'(r), 8'(d), acc);
        nexp = m_write(r, d);
        checks++;
        if (obs_a.size() != nexp) begin
          errors++; $display("FAIL rand_write_count op %0d reg %0d got %0d, required %0d", t, r, obs_a.size(), nexp);
        end else if (nexp == 1) begin
          checks++;
          if (obs_a[0].addr != cur_before || obs_a[0].vd != d || obs_a[0].cd != color_before || !obs_a[0].ok) begin
            errors++;
            $display("FAIL rand_write op %0d addr=%h vd=%h cd=%h, required %h %h %h",
                     t, obs_a[0].addr, obs_a[0].vd, obs_a[0].cd, cur_before, d, color_before);
          end
        end
      end else begin
        host_read(3'(r), v);
        expv = m_read(r);
        checks++;
        if (int'(v) != expv || $isunknown(v)) begin
          errors++; $display("FAIL rand_read op %0d reg %0d got %h, required %h", t, r, v, expv);
        end
      end
      checks++;
      if (int'(cur_a) != m_cur || en_a !== 1'(m_ctrl & 1)) begin
        errors++; $display("FAIL rand_cursor op %0d cur=%h en=%b, required %h %0d", t, cur_a, en_a, m_cur, m_ctrl & 1);
      end
    end
  endtask

  task automatic test_small_geom();
    int acc;
    logic [7:0] v;
    rst_n = 1'b0; sel = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    host_write(3'd2, 8'h7F, acc);
    host_write(3'd3, 8'h07, acc);
    obs_b.delete();
    host_write(3'd1, 8'h55, acc);
    checks++;
    if (obs_b.size() != 1 || obs_b[0].addr != 'h77F || obs_b[0].vd != 'h55 || obs_b[0].cd != 'h07) begin
      errors++; $display("FAIL small_write got %0d writes first addr %h, required 1 at 77f", obs_b.size(),
                         obs_b.size() > 0 ? obs_b[0].addr : -1);
    end
    checks++;
    if (cur_b !== 11'd0) begin errors++; $display("FAIL small_wrap got %h, required 000", cur_b); end
    host_read(3'd0, v);
    checks++; if (v !== 8'hA1) begin errors++; $display("FAIL small_status got %h, required a1", v); end
    host_write(3'd2, 8'h80, acc);
    host_write(3'd3, 8'h07, acc);
    checks++;
    if (cur_b !== 11'd0) begin errors++; $display("FAIL small_oob_cursor got %h, required 000", cur_b); end
    host_read(3'd0, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL small_err got %h, required a5", v); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_no_autoinc();
    test_range_err();
    test_fill();
    test_reset_mid_fill();
    test_hold_cs();
    test_random();
    test_small_geom();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
